paddle_controller: RTL and testbench

Parametrised automatic paddle controller for the pong engine; successor to the fixed-parameter paddle AI. On each frame tick it moves one paddle's top coordinate toward a target and clamps the paddle inside the playfield. A four-state mode machine selects the target: screen centre when idle, a reaction delay, then ball tracking. Sits between the ball-physics block and the renderer, one instance per CPU-controlled paddle.

---
 rtl/paddle_controller.sv | 151 +++++++++++++++
 tb/tb_paddle_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/paddle_controller.sv
// Frame-tick paddle AI: steps y_top toward centre or ball and clamps it to the playfield; updates 1 cycle after frame_tick.
// No backpressure: state advances only on frame_tick and outputs hold between ticks; x follows paddle_x every cycle.
module paddle_controller #(
    parameter int COORD_W     = 16,
    parameter int HALF_PADDLE = 50,
    parameter int STEP        = 5,
    parameter int DEADBAND    = 2,
    parameter int REACT_TICKS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 enable,
    input  logic [2*COORD_W-1:0] dimensions,
    input  logic [2*COORD_W-1:0] ball_pos,
    input  logic                 ball_approaching,
    input  logic [COORD_W-1:0]   paddle_x,
    output logic [2*COORD_W-1:0] paddle_pos,
    output logic [1:0]           state,
    output logic                 moving
);

    localparam int SW    = COORD_W + 2;
    localparam int CNT_W = (REACT_TICKS > 0) ? $clog2(REACT_TICKS + 1) : 1;

    localparam logic signed [SW-1:0] HALF_S = SW'(HALF_PADDLE);
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
    localparam logic signed [SW-1:0] DB_S   = SW'(DEADBAND);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        ST_CENTER = 2'd0,
        ST_WAIT   = 2'd1,
        ST_TRACK  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    pos_t dims, ball;
    assign dims = dimensions;
    assign ball = ball_pos;

    logic unused_bits;
    assign unused_bits = ^{dims.x, ball.x};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic               moving_q, moving_d;

    // Playfield-derived limits, saturated at zero for undersized fields
    logic signed [SW-1:0] base_raw, ymax_raw, base_s, ymax_s;
    logic [COORD_W-1:0]   base;

    always_comb begin
        base_raw = $signed({3'b000, dims.y[COORD_W-1:1]}) - HALF_S;
        ymax_raw = $signed({2'b00, dims.y}) - (HALF_S <<< 1);
        base_s   = (base_raw < 0) ? '0 : base_raw;
        ymax_s   = (ymax_raw < 0) ? '0 : ymax_raw;
        base     = base_s[COORD_W-1:0];
    end

    logic                 do_move;
    logic signed [SW-1:0] tgt, tol, y_s, d, absd, step, y_mv, y_cl;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        moving_d = moving_q;
        x_d      = paddle_x;
        do_move  = 1'b0;
        tgt      = base_s;
        tol      = '0;
        y_s      = $signed({2'b00, y_q});

        if (frame_tick) begin
            if (!enable) begin
                state_d = ST_HOLD;
            end else begin
                case (state_q)
                    ST_HOLD: state_d = ST_CENTER;
                    ST_CENTER: begin
                        if (ball_approaching) begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(REACT_TICKS);
                        end else begin
                            do_move = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!ball_approaching)  state_d = ST_CENTER;
                        else if (cnt_q == '0)   state_d = ST_TRACK;
                        else                    cnt_d   = cnt_q - CNT_W'(1);
                    end
                    default: begin
                        if (!ball_approaching) begin
                            state_d = ST_CENTER;
                        end else begin
                            do_move = 1'b1;
                            tgt     = $signed({2'b00, ball.y}) - HALF_S;
                            tol     = DB_S;
                        end
                    end
                endcase
            end
        end

        d    = tgt - y_s;
        absd = (d < 0) ? -d : d;
        step = (absd < STEP_S) ? absd : STEP_S;
        if (!do_move || absd <= tol) y_mv = y_s;
        else if (d < 0)              y_mv = y_s - step;
        else                         y_mv = y_s + step;

        // Clamp runs on every tick so a shrunken playfield re-pins y even in HOLD
        if (y_mv < 0)           y_cl = '0;
        else if (y_mv > ymax_s) y_cl = ymax_s;
        else                    y_cl = y_mv;

        if (frame_tick) begin
            y_d      = y_cl[COORD_W-1:0];
            moving_d = (y_cl[COORD_W-1:0] != y_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CENTER;
            cnt_q    <= '0;
            y_q      <= base;
            moving_q <= 1'b0;
            x_q      <= paddle_x;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            moving_q <= moving_d;
            x_q      <= x_d;
        end
    end

    assign paddle_pos = {x_q, y_q};
    assign state      = state_q;
    assign moving     = moving_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with hand-computed expectations (height 480: base 190, ymax 380).
module tb_paddle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        enable;
    logic [31:0] dimensions;
    logic [31:0] ball_pos;
    logic        ball_approaching;
    logic [15:0] paddle_x;
    logic [31:0] paddle_pos;
    logic [1:0]  state;
    logic        moving;

    int n_checks = 0;
    int n_pass   = 0;

    paddle_controller dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick       (frame_tick),
        .enable           (enable),
        .dimensions       (dimensions),
        .ball_pos         (ball_pos),
        .ball_approaching (ball_approaching),
        .paddle_x         (paddle_x),
        .paddle_pos       (paddle_pos),
        .state            (state),
        .moving           (moving)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Called at a negedge; holds frame_tick for n consecutive edges, returns at a negedge.
    task automatic tick(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_pos(input string tag, input int s, input int y, input int mv);
        check_eq({tag, ".state"},  32'(state),             32'(s));
        check_eq({tag, ".y"},      32'(paddle_pos[15:0]),  32'(y));
        check_eq({tag, ".moving"}, 32'(moving),            32'(mv));
    endtask

    initial begin
        rst              = 1'b1;
        frame_tick       = 1'b0;
        enable           = 1'b1;
        dimensions       = {16'd640, 16'd480};
        ball_pos         = {16'd320, 16'd240};
        ball_approaching = 1'b0;
        paddle_x         = 16'd20;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("reset.x", 32'(paddle_pos[31:16]), 32'd20);
        expect_pos("reset", 0, 190, 0);

        // Reaction delay: WAIT for 4 ticks, TRACK on the 5th, no movement meanwhile
        ball_approaching = 1'b1;
        ball_pos         = {16'd320, 16'd400};
        tick(1); expect_pos("wait1", 1, 190, 0);
        tick(1); expect_pos("wait2", 1, 190, 0);
        tick(1); expect_pos("wait3", 1, 190, 0);
        tick(1); expect_pos("wait4", 1, 190, 0);
        tick(1); expect_pos("track_enter", 2, 190, 0);

        // Partial step then deadband
        ball_pos = {16'd320, 16'd243};
        tick(1); expect_pos("partial", 2, 193, 1);
        ball_pos = {16'd320, 16'd245};
        tick(1); expect_pos("deadband", 2, 193, 0);
        ball_pos = {16'd320, 16'd400};
        tick(1); expect_pos("full_step", 2, 198, 1);

        // Clamp at ymax using back-to-back ticks
        ball_pos = {16'd320, 16'd479};
        tick(36); expect_pos("clamp_near", 2, 378, 1);
        tick(1);  expect_pos("clamp_hit", 2, 380, 1);
        tick(1);  expect_pos("clamp_stay", 2, 380, 0);
        tick(20); expect_pos("clamp_long", 2, 380, 0);

        // Return to centre: 38 moving ticks after the transition tick
        ball_approaching = 1'b0;
        tick(1);  expect_pos("ret_enter", 0, 380, 0);
        tick(1);  expect_pos("ret_first", 0, 375, 1);
        tick(36); expect_pos("ret_mid", 0, 195, 1);
        tick(1);  expect_pos("ret_last", 0, 190, 1);
        tick(1);  expect_pos("ret_idle", 0, 190, 0);

        // x follows paddle_x without a tick; other outputs stay put
        paddle_x = 16'd33;
        @(negedge clk);
        check_eq("x_follow", 32'(paddle_pos[31:16]), 32'd33);
        expect_pos("no_tick", 0, 190, 0);

        // Hold freezes y
        ball_approaching = 1'b1;
        ball_pos         = {16'd320, 16'd400};
        tick(5); expect_pos("track2", 2, 190, 0);
        tick(2); expect_pos("track2_mv", 2, 200, 1);
        enable = 1'b0;
        tick(1);  expect_pos("hold_enter", 3, 200, 0);
        tick(10); expect_pos("hold_frozen", 3, 200, 0);
        enable = 1'b1;
        tick(1); expect_pos("hold_exit", 0, 200, 0);
        tick(1); expect_pos("wait_b1", 1, 200, 0);
        tick(1); expect_pos("wait_b2", 1, 200, 0);

        // Reset wins over a simultaneous tick
        rst = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0;
        expect_pos("midop_rst", 0, 190, 0);

        // Playfield shrink re-clamps in HOLD
        enable = 1'b0;
        tick(1); expect_pos("hold2", 3, 190, 0);
        dimensions = {16'd640, 16'd250};
        tick(1); expect_pos("shrink", 3, 150, 1);
        tick(1); expect_pos("shrink_idle", 3, 150, 0);
        dimensions = {16'd640, 16'd80};
        tick(1); expect_pos("tiny_field", 3, 0, 1);

        // Negative tracking target clamps to 0
        dimensions = {16'd640, 16'd480};
        enable     = 1'b1;
        tick(1); expect_pos("hold3_exit", 0, 0, 0);
        tick(5); expect_pos("track3", 2, 0, 0);
        tick(4); expect_pos("climb", 2, 20, 1);
        ball_pos = {16'd320, 16'd10};
        tick(4); expect_pos("descend", 2, 0, 1);
        tick(1); expect_pos("floor", 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
